// File: rtl/width_gearbox.sv
// Width gearbox: repacks an MSB-first stream of IN_W-bit beats into OUT_W-bit words,
// with an optional flush that emits residual bits as a zero-padded final word.
module width_gearbox #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [IN_W-1:0]  data_in,
    input  logic             flush,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [OUT_W-1:0] data_out,
    output logic             last_out
);

    localparam int BUF_W = IN_W + OUT_W;
    localparam int FW    = $clog2(BUF_W + 1);

    logic [BUF_W-1:0] buf_r,   buf_nx_s;
    logic [FW-1:0]    fill_r,  fill_nx_s;
    logic [OUT_W-1:0] out_r,   out_nx_s;
    logic             valid_r, valid_nx_s;
    logic             last_r,  last_nx_s;
    logic             pend_r,  pend_nx_s;
    logic             ready_r, ready_nx_s;

    logic             accept_s;
    logic             slot_free_s;
    logic [BUF_W-1:0] beat_s;
    logic [BUF_W-1:0] pre_s;
    logic [FW-1:0]    pre_fill_s;

    assign accept_s    = valid_in && ready_r;
    assign slot_free_s = !valid_r || ready_out;

    // Merge the accepted beat below the current fill and pick this edge's output action
    always_comb begin
        beat_s     = accept_s ? {data_in, {OUT_W{1'b0}}} : {BUF_W{1'b0}};
        pre_s      = buf_r | (beat_s >> fill_r);
        pre_fill_s = fill_r + (accept_s ? FW'(IN_W) : {FW{1'b0}});

        buf_nx_s   = pre_s;
        fill_nx_s  = pre_fill_s;
        out_nx_s   = out_r;
        valid_nx_s = valid_r && !ready_out;
        last_nx_s  = last_r;
        pend_nx_s  = pend_r ? 1'b1 : flush;

        if (slot_free_s && (pre_fill_s >= FW'(OUT_W))) begin
            out_nx_s   = pre_s[BUF_W-1 -: OUT_W];
            valid_nx_s = 1'b1;
            last_nx_s  = 1'b0;
            buf_nx_s   = pre_s << OUT_W;
            fill_nx_s  = pre_fill_s - FW'(OUT_W);
        end else if (pend_r && slot_free_s && (pre_fill_s != {FW{1'b0}})) begin
            // Bits below the fill are always zero, so the top slice is already padded
            out_nx_s   = pre_s[BUF_W-1 -: OUT_W];
            valid_nx_s = 1'b1;
            last_nx_s  = 1'b1;
            buf_nx_s   = {BUF_W{1'b0}};
            fill_nx_s  = {FW{1'b0}};
            pend_nx_s  = 1'b0;
        end else if (pend_r && (pre_fill_s == {FW{1'b0}})) begin
            pend_nx_s  = 1'b0;
        end else begin
            pend_nx_s  = pend_nx_s;
        end

        // fill + IN_W <= BUF_W reduces to fill <= OUT_W
        ready_nx_s = (fill_nx_s <= FW'(OUT_W)) && !pend_nx_s;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_r   <= {BUF_W{1'b0}};
            fill_r  <= {FW{1'b0}};
            out_r   <= {OUT_W{1'b0}};
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            pend_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            buf_r   <= buf_nx_s;
            fill_r  <= fill_nx_s;
            out_r   <= out_nx_s;
            valid_r <= valid_nx_s;
            last_r  <= last_nx_s;
            pend_r  <= pend_nx_s;
            ready_r <= ready_nx_s;
        end
    end

    assign ready_in  = ready_r;
    assign valid_out = valid_r;
    assign data_out  = out_r;
    assign last_out  = last_r;

endmodule

// File: doc/width_gearbox.md
WIDTH_GEARBOX -- requirements
Module: width_gearbox

Interface
REQ-001 Parameter IN_W, default 8, input beat width in bits; legal range 1..64.
REQ-002 Parameter OUT_W, default 12, output word width in bits; legal range 1..64; IN_W need not divide OUT_W and OUT_W need not divide IN_W.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 valid_in  input  1  input beat valid.
REQ-006 ready_in  output  1  block can accept a beat this cycle.
REQ-007 data_in  input  IN_W  input beat, MSB transmitted first.
REQ-008 flush  input  1  single-cycle request to drain residual bits as a padded final word.
REQ-009 valid_out  output  1  output word valid; registered.
REQ-010 ready_out  input  1  downstream accepts the word this cycle.
REQ-011 data_out  output  OUT_W  output word; registered.
REQ-012 last_out  output  1  marks a flush-generated (padded) word; qualified by valid_out.

Function
REQ-013 Internal buffer: BUF_W = IN_W + OUT_W bits, MSB-aligned, with fill count 0..BUF_W.
REQ-014 A beat is accepted when valid_in && ready_in; an output slot is released when valid_out && ready_out.
REQ-015 ready_in SHALL be a function of registered state only: 1 when (fill + IN_W <= BUF_W) and no flush is pending; otherwise 0.
REQ-016 Bit order: stream is the concatenation of accepted beats, MSB first; data_out[OUT_W-1] SHALL be the oldest unconsumed bit.
REQ-017 Bypass rule: each edge forms pre = buffer plus the beat accepted that edge, appended below the existing fill.
REQ-018 If the output register is empty or being released that edge, and pre_fill >= OUT_W, data_out SHALL load the top OUT_W bits of pre.
REQ-019 On that load: valid_out=1, last_out=0, and the buffer SHALL shift left by OUT_W with fill = pre_fill - OUT_W.
REQ-020 If no word is loaded and the slot is released, valid_out SHALL drop to 0.
REQ-021 Latency: a word SHALL become valid on the edge that accepts its completing beat (one clock after that beat is presented), provided the output slot is free.
REQ-022 At most one output word SHALL be loaded per edge.
REQ-023 Throughput: for IN_W <= OUT_W with ready_out held 1, ready_in SHALL remain 1 continuously and no input bubble SHALL be inserted.
REQ-024 Backpressure: with valid_out=1 and ready_out=0, data_out, last_out and valid_out SHALL hold; beats continue to be accepted until ready_in drops; no bit SHALL be lost or duplicated.
REQ-025 flush SHALL set a pending flag; a beat accepted in the same cycle as flush belongs before the flush boundary.
REQ-026 While flush is pending, normal full-word extraction continues.
REQ-027 Once pending, 0 < fill < OUT_W and the slot is free: data_out = residual bits left-aligned, zero-padded below; last_out=1; fill=0; pending cleared.
REQ-028 Once pending and fill == 0: pending clears with no output word.
REQ-029 If a flush arrives when the stream is exactly word-aligned, the last full word SHALL carry last_out=0 and no padded word SHALL be emitted.
REQ-030 flush asserted while already pending SHALL be ignored.
REQ-031 Fill counter width SHALL be $clog2(BUF_W+1); fill SHALL never exceed BUF_W or go negative.

Reset
REQ-032 While rst_n=0: valid_out=0, data_out=0, last_out=0, fill=0, buffer=0, flush pending=0.
REQ-033 ready_in=1 in the first cycle after reset release.
REQ-034 Reset asserted mid-stream SHALL discard all partial bits; the first word after reset SHALL contain only post-reset beats.

Verification (IN_W=8, OUT_W=12 unless noted)
REQ-035 Beats A1,B2,C3 on consecutive cycles with ready_out=1 -> data_out A1B valid on cycle 2, then 2C3 on cycle 3; ready_in stays 1.
REQ-036 Beats A1,B2 then flush, ready_out=1 -> A1B (last_out=0), then 200 with last_out=1, then valid_out=0.
REQ-037 ready_out=0 while streaming 01..06 -> ready_in drops once fill+8>20; after release, words 010, 203, 040, 506 arrive in order with none lost.
REQ-038 IN_W=12, OUT_W=8: beats ABC,DEF with ready_out=1 -> words AB, CD, EF; ready_in deasserts as needed and no bits are dropped.
REQ-039 Reset pulsed after a single beat 7E, then beats 11,22 and flush -> output 112 then 200 (last_out=1); no 7E bits appear.
REQ-040 flush with an empty buffer, and flush right after three beats (word-aligned) -> no padded word in either case, and pending clears within 2 cycles.
